// File: rtl/alu_iter.sv
// Registered 32-bit execute unit: single-cycle logic/add/sub/slt, iterative
// one-bit-per-cycle shifts under a start/done/busy handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; single-cycle ops and shift-by-0 finish here
// S_SHIFT | shifting acc one bit per edge until cnt reaches terminal count
module alu_iter #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       operation,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             done,
   output logic             busy,
   output logic             illegal
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;
   localparam logic [3:0] OP_SLL = 4'b1000;
   localparam logic [3:0] OP_SRL = 4'b1001;
   localparam logic [3:0] OP_SRA = 4'b1010;

   localparam logic [1:0] SH_SLL = 2'b00;
   localparam logic [1:0] SH_SRL = 2'b01;

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [1:0]       sh_type_q, sh_type_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             illegal_q, illegal_d;

   logic [WIDTH-1:0] alu_res;
   logic             alu_legal;
   logic             is_shift;
   logic [SHW-1:0]   sh_amt;
   logic [WIDTH-1:0] acc_sh;

   assign sh_amt = b[SHW-1:0];

   always_comb begin
      alu_res   = '0;
      alu_legal = 1'b1;
      is_shift  = 1'b0;
      case (operation)
         OP_AND: alu_res = a & b;
         OP_OR:  alu_res = a | b;
         OP_ADD: alu_res = a + b;
         OP_SUB: alu_res = a - b;
         OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_NOR: alu_res = ~(a | b);
         OP_SLL, OP_SRL, OP_SRA: begin
            // shift by 0 completes immediately and returns a unchanged
            alu_res  = a;
            is_shift = 1'b1;
         end
         default: alu_legal = 1'b0;
      endcase
   end

   always_comb begin
      case (sh_type_q)
         SH_SLL:  acc_sh = {acc_q[WIDTH-2:0], 1'b0};
         SH_SRL:  acc_sh = {1'b0, acc_q[WIDTH-1:1]};
         default: acc_sh = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      endcase
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      sh_type_d = sh_type_q;
      result_d  = result_q;
      zero_d    = zero_q;
      done_d    = 1'b0;
      busy_d    = busy_q;
      illegal_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (is_shift && (sh_amt != '0)) begin
                  acc_d     = a;
                  cnt_d     = sh_amt;
                  sh_type_d = operation[1:0];
                  busy_d    = 1'b1;
                  state_d   = S_SHIFT;
               end else begin
                  result_d  = alu_res;
                  zero_d    = (alu_res == '0);
                  done_d    = 1'b1;
                  illegal_d = ~alu_legal;
               end
            end
         end
         S_SHIFT: begin
            acc_d = acc_sh;
            cnt_d = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
               result_d = acc_sh;
               zero_d   = (acc_sh == '0);
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         acc_q     <= '0;
         cnt_q     <= '0;
         sh_type_q <= SH_SLL;
         result_q  <= '0;
         zero_q    <= 1'b1;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         sh_type_q <= sh_type_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         illegal_q <= illegal_d;
      end
   end

   assign result  = result_q;
   assign zero    = zero_q;
   assign done    = done_q;
   assign busy    = busy_q;
   assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter: hand-computed vectors checked with immediate
// assertions one cycle after each accepting edge.
module tb_alu_iter;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  operation;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] result;
   logic        zero;
   logic        done;
   logic        busy;
   logic        illegal;

   int n_tests = 0;
   int n_fail  = 0;
   int k;
   int busy_cnt;
   int done_seen;

   alu_iter #(.WIDTH(32), .SHW(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .operation (operation),
      .a         (a),
      .b         (b),
      .result    (result),
      .zero      (zero),
      .done      (done),
      .busy      (busy),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // present one request for a single edge, then drop start
   task automatic issue(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb);
      start     = 1'b1;
      operation = op;
      a         = va;
      b         = vb;
      tick();
      start     = 1'b0;
      operation = 4'b0000;
      a         = 32'h0;
      b         = 32'h0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; operation = 4'b0000; a = '0; b = '0;
      tick();
      tick();
      check("rst_result", result, 32'h0);
      check("rst_zero", {31'h0, zero}, 32'h1);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_done", {31'h0, done}, 32'h0);
      check("rst_illegal", {31'h0, illegal}, 32'h0);
      reset = 1'b0;
      tick();

      issue(4'b0010, 32'h7FFF_FFFF, 32'h1);
      check("add_result", result, 32'h8000_0000);
      check("add_zero", {31'h0, zero}, 32'h0);
      check("add_done", {31'h0, done}, 32'h1);
      tick();
      check("add_done_once", {31'h0, done}, 32'h0);
      check("add_hold", result, 32'h8000_0000);

      issue(4'b0110, 32'd5, 32'd5);
      check("sub_result", result, 32'h0);
      check("sub_zero", {31'h0, zero}, 32'h1);

      // back-to-back single-cycle ops, one per edge
      issue(4'b0111, 32'hFFFF_FFFF, 32'h1);
      check("slt_neg", result, 32'h1);
      check("slt_done", {31'h0, done}, 32'h1);
      issue(4'b0111, 32'h1, 32'hFFFF_FFFF);
      check("slt_pos", result, 32'h0);
      check("slt_b2b_done", {31'h0, done}, 32'h1);
      issue(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00);
      check("and", result, 32'hF000_F000);
      issue(4'b0001, 32'hF0F0_0000, 32'h0000_0F0F);
      check("or", result, 32'hF0F0_0F0F);
      issue(4'b1100, 32'hF0F0_0000, 32'h0000_0F0F);
      check("nor", result, 32'h0F0F_F0F0);
      tick();

      // SRA by 31 with an ADD request ignored mid-shift
      issue(4'b1010, 32'h8000_0000, 32'd31);
      k = 0; busy_cnt = 0;
      while (!done && k < 40) begin
         if (busy) busy_cnt++;
         if (k == 10) begin
            start = 1'b1; operation = 4'b0010; a = 32'd1; b = 32'd1;
         end
         if (k == 11) start = 1'b0;
         tick();
         k++;
      end
      check("sra_latency", k, 32'd31);
      check("sra_busy_cycles", busy_cnt, 32'd31);
      check("sra_result", result, 32'hFFFF_FFFF);
      check("sra_busy_end", {31'h0, busy}, 32'h0);
      tick();
      check("sra_no_queued", {31'h0, done}, 32'h0);
      check("sra_hold", result, 32'hFFFF_FFFF);

      issue(4'b1001, 32'h0000_00F0, 32'd4);
      k = 0;
      while (!done && k < 40) begin
         tick();
         k++;
      end
      check("srl_latency", k, 32'd4);
      check("srl_result", result, 32'h0000_000F);
      // new request in the same cycle done is high
      issue(4'b1000, 32'h1, 32'h0);
      check("sll0_result", result, 32'h1);
      check("sll0_done", {31'h0, done}, 32'h1);
      check("sll0_busy", {31'h0, busy}, 32'h0);

      issue(4'b0101, 32'h1234_5678, 32'h9ABC_DEF0);
      check("ill_result", result, 32'h0);
      check("ill_flag", {31'h0, illegal}, 32'h1);
      check("ill_done", {31'h0, done}, 32'h1);
      check("ill_zero", {31'h0, zero}, 32'h1);
      tick();
      check("ill_clear", {31'h0, illegal}, 32'h0);

      issue(4'b0010, 32'd7, 32'd0);
      check("pre_rst_add", result, 32'd7);

      // reset mid-shift
      issue(4'b1000, 32'h1, 32'd20);
      done_seen = 0;
      for (int i = 0; i < 10; i++) begin
         if (done) done_seen++;
         tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_result", result, 32'h0);
      check("abort_busy", {31'h0, busy}, 32'h0);
      for (int i = 0; i < 25; i++) begin
         if (done) done_seen++;
         tick();
      end
      check("abort_no_done", done_seen, 32'd0);
      issue(4'b0010, 32'd2, 32'd3);
      check("post_abort_add", result, 32'd5);
      check("post_abort_done", {31'h0, done}, 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
